// File: rtl/spi_master_pkg.sv
`default_nettype none
// ============================================================================
// Module  : spi_pkg
// Brief   : Shared SPI types and constants for the master and slave stages.
// Revision: 1.0
// ============================================================================
package spi_pkg;

   localparam int SPI_DEFAULT_WIDTH = 10;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      SHIFT = 3'd2,
      HOLD  = 3'd3,
      GAP   = 3'd4
   } spi_state_e;

endpackage
`default_nettype wire

// File: rtl/spi_master_if.sv
`default_nettype none
// ============================================================================
// Module  : spi_master_if
// Brief   : Host handshake plus SPI bus bundle between master and its users.
// Revision: 1.0
// ============================================================================
interface spi_master_if
   import spi_pkg::*;
#(
   parameter int WIDTH = SPI_DEFAULT_WIDTH
);
   logic             start;
   logic [WIDTH-1:0] tx_data;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] rx_data;
   logic             sclk;
   logic             ssel;
   logic             mosi;
   logic             miso;

   modport master (
      input  start, tx_data, miso,
      output busy, done, rx_data, sclk, ssel, mosi
   );

   modport slave (
      output start, tx_data, miso,
      input  busy, done, rx_data, sclk, ssel, mosi
   );
endinterface
`default_nettype wire

// File: rtl/spi_master_clk_div.sv
`default_nettype none
// ============================================================================
// Module  : spi_clk_div
// Brief   : Half-period tick generator; tick fires every CLK_DIV enabled clocks.
// Revision: 1.0
// ============================================================================
module spi_clk_div #(
   parameter int CLK_DIV = 4
) (
   input  wire logic clock,
   input  wire logic reset,
   input  wire logic clear,
   input  wire logic enable,
   output logic      tick
);
   localparam int                 c_CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(CLK_DIV - 1);

   logic [c_CNT_W-1:0] r_count;
   logic               w_tick;

   assign w_tick = enable && (r_count == c_LAST);
   assign tick   = w_tick;

   always_ff @(posedge clock) begin
      if (reset || clear || w_tick) begin
         r_count <= '0;
      end else if (enable) begin
         r_count <= r_count + 1'b1;
      end
   end
endmodule
`default_nettype wire

// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
// Module  : spi_master
// Brief   : WIDTH-bit full-duplex SPI master, sclk idle low, MSB first.
//           SPI_MASTER_MISO_SYNC_EN adds a two-flop miso synchronizer.
// Revision: 1.0
// ============================================================================
module spi_master
   import spi_pkg::*;
#(
   parameter int WIDTH   = SPI_DEFAULT_WIDTH,
   parameter int CLK_DIV = 4
) (
   input  wire logic    clock,
   input  wire logic    reset,
   spi_master_if.master bus
);
   localparam int                 c_BIT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [c_BIT_W-1:0] c_LAST_BIT = c_BIT_W'(WIDTH - 1);

   spi_state_e         r_state;
   spi_state_e         w_state_nxt;
   logic [WIDTH-1:0]   r_tx_shift;
   logic [WIDTH-1:0]   r_rx_shift;
   logic [WIDTH-1:0]   r_rx_data;
   logic [c_BIT_W-1:0] r_bit_cnt;
   logic               r_busy;
   logic               r_done;
   logic               r_sclk;
   logic               r_ssel;
   logic               r_mosi;
   logic               w_div_en;
   logic               w_tick;
   logic               w_accept;
   logic               w_rise;
   logic               w_fall;
   logic               w_last_fall;
   logic               w_finish;
   logic               w_release;
   logic               w_sample;
   logic               w_miso_bit;

   assign w_div_en = (r_state != IDLE);

   spi_clk_div #(
      .CLK_DIV (CLK_DIV)
   ) u_clk_div (
      .clock  (clock),
      .reset  (reset),
      .clear  (w_accept),
      .enable (w_div_en),
      .tick   (w_tick)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_accept)    w_state_nxt = SETUP;
         SETUP:   if (w_rise)      w_state_nxt = SHIFT;
         SHIFT:   if (w_last_fall) w_state_nxt = HOLD;
         HOLD:    if (w_finish)    w_state_nxt = GAP;
         GAP:     if (w_release)   w_state_nxt = IDLE;
         default:                  w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      w_accept    = 1'b0;
      w_rise      = 1'b0;
      w_fall      = 1'b0;
      w_last_fall = 1'b0;
      w_finish    = 1'b0;
      w_release   = 1'b0;
      case (r_state)
         IDLE:  w_accept = bus.start;
         SETUP: w_rise   = w_tick;
         SHIFT: begin
            w_rise      = w_tick && !r_sclk;
            w_fall      = w_tick && r_sclk;
            w_last_fall = w_tick && r_sclk && (r_bit_cnt == c_LAST_BIT);
         end
         HOLD:  w_finish  = w_tick;
         GAP:   w_release = w_tick;
         default: ;
      endcase
   end

`ifdef SPI_MASTER_MISO_SYNC_EN
   logic [1:0] r_miso_sync;
   logic [1:0] r_rise_dly;

   // Sample two clocks after the rise, once the synchronized bit has arrived.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_miso_sync <= '0;
         r_rise_dly  <= '0;
      end else begin
         r_miso_sync <= {r_miso_sync[0], bus.miso};
         r_rise_dly  <= {r_rise_dly[0], w_rise};
      end
   end

   assign w_miso_bit = r_miso_sync[1];
   assign w_sample   = r_rise_dly[1];
`else
   assign w_miso_bit = bus.miso;
   assign w_sample   = w_rise;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         r_tx_shift <= '0;
         r_rx_shift <= '0;
         r_rx_data  <= '0;
         r_bit_cnt  <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_sclk     <= 1'b0;
         r_ssel     <= 1'b1;
         r_mosi     <= 1'b0;
      end else begin
         r_done <= w_finish;
         if (w_accept) begin
            r_tx_shift <= bus.tx_data;
            r_mosi     <= bus.tx_data[WIDTH-1];
            r_ssel     <= 1'b0;
            r_busy     <= 1'b1;
            r_bit_cnt  <= '0;
         end
         // The bit counter advances on every rise except the first one.
         if (w_rise) begin
            r_sclk <= 1'b1;
            if (r_state == SHIFT) r_bit_cnt <= r_bit_cnt + 1'b1;
         end
         if (w_fall) begin
            r_sclk     <= 1'b0;
            r_tx_shift <= r_tx_shift << 1;
            r_mosi     <= w_last_fall ? 1'b0 : r_tx_shift[WIDTH-2];
         end
         if (w_sample) r_rx_shift <= {r_rx_shift[WIDTH-2:0], w_miso_bit};
         if (w_finish) begin
            r_ssel    <= 1'b1;
            r_rx_data <= r_rx_shift;
         end
         if (w_release) r_busy <= 1'b0;
      end
   end

   assign bus.busy    = r_busy;
   assign bus.done    = r_done;
   assign bus.rx_data = r_rx_data;
   assign bus.sclk    = r_sclk;
   assign bus.ssel    = r_ssel;
   assign bus.mosi    = r_mosi;
endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// ============================================================================
// Module  : tb_spi_master
// Brief   : Scoreboard bench for spi_master (10-bit/div-4 and 8-bit fast DUTs).
// Revision: 1.0
// ============================================================================
module tb_spi_master;
`ifdef SPI_MASTER_MISO_SYNC_EN
   localparam int B_DIV = 3;
`else
   localparam int B_DIV = 2;
`endif

   typedef struct {
      logic [9:0] data;
      int         acc;
   } exp_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   cyc   = 0;
   int   n_checks = 0;
   int   n_errors = 0;

   exp_t sb[$];
   exp_t cur;
   bit   in_xfer   = 1'b0;
   logic prev_busy = 1'b0;
   logic prev_sclk = 1'b0;
   int   n_rise, n_done, n_ssel_low;

   logic       mode_slave = 1'b0;
   logic       glitch_en  = 1'b0;
   logic       glitch     = 1'b0;
   logic [9:0] s_shift, s_latched;
   logic       s_miso;

   spi_master_if #(.WIDTH(10)) bus_a ();
   spi_master_if #(.WIDTH(8))  bus_b ();

   spi_master #(.WIDTH(10), .CLK_DIV(4)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus_a)
   );

   spi_master #(.WIDTH(8), .CLK_DIV(B_DIV)) dut_b (
      .clock (clock),
      .reset (reset),
      .bus   (bus_b)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc = cyc + 1;

   assign bus_a.miso = (mode_slave ? s_miso : bus_a.mosi) ^ glitch;
   assign bus_b.miso = bus_b.mosi;

   // Slave stage model: loads 10'h155 on select, shifts on rise, drives on fall.
   always @(negedge bus_a.ssel) begin
      s_shift = 10'h155;
      s_miso  = s_shift[9];
   end
   always @(posedge bus_a.sclk) s_shift = {s_shift[8:0], bus_a.mosi};
   always @(negedge bus_a.sclk) s_miso = s_shift[9];
   always @(posedge bus_a.ssel) s_latched = s_shift;

   always @(negedge bus_a.sclk) begin
      if (glitch_en) begin
         @(posedge clock);
         #2 glitch = 1'b1;
         @(posedge clock);
         #2 glitch = 1'b0;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   always @(negedge clock) begin
      if (reset) begin
         if (in_xfer && sb.size() != 0) void'(sb.pop_front());
         in_xfer   = 1'b0;
         prev_busy = 1'b0;
         prev_sclk = 1'b0;
      end else begin
         if (bus_a.busy && !prev_busy) begin
            check_eq("accept_queued", (sb.size() != 0), 1);
            if (sb.size() != 0) begin
               cur = sb[0];
               check_eq("accept_t", cyc, cur.acc);
               in_xfer    = 1'b1;
               n_rise     = 0;
               n_done     = 0;
               n_ssel_low = 0;
            end
         end
         if (in_xfer) begin
            if (bus_a.sclk && !prev_sclk) n_rise++;
            if (!bus_a.ssel) n_ssel_low++;
            if (bus_a.done) begin
               n_done++;
               check_eq("rx_data", bus_a.rx_data, cur.data);
               check_eq("done_t", cyc - cur.acc, 84);
               check_eq("sclk_rises", n_rise, 10);
            end
            if (!bus_a.busy) begin
               check_eq("busy_fall_t", cyc - cur.acc, 88);
               check_eq("ssel_low_cycles", n_ssel_low, 84);
               check_eq("done_count", n_done, 1);
               void'(sb.pop_front());
               in_xfer = 1'b0;
            end
         end
         prev_busy = bus_a.busy;
         prev_sclk = bus_a.sclk;
      end
   end

   task automatic wait_drain();
      int g = 0;
      while (sb.size() != 0 && g < 1000) begin
         @(negedge clock);
         g++;
      end
      check_eq("drain", sb.size(), 0);
   endtask

   task automatic run_xfer(input logic [9:0] tx, input logic [9:0] exp_rx);
      exp_t e;
      @(negedge clock);
      bus_a.tx_data = tx;
      bus_a.start   = 1'b1;
      e.data = exp_rx;
      e.acc  = cyc + 1;
      sb.push_back(e);
      @(negedge clock);
      bus_a.start   = 1'b0;
      bus_a.tx_data = ~tx;
      wait_drain();
   endtask

   task automatic run_back_to_back();
      logic [9:0] d [3];
      exp_t       e;
      int         p;
      d[0] = 10'h3A1;
      d[1] = 10'h05E;
      d[2] = 10'h2C7;
      @(negedge clock);
      bus_a.tx_data = d[0];
      bus_a.start   = 1'b1;
      p = cyc + 1;
      for (int k = 0; k < 3; k++) begin
         e.data = d[k];
         e.acc  = p + 89 * k;
         sb.push_back(e);
      end
      for (int k = 0; k < 3; k++) begin
         while (cyc < p + 89 * k + 44) @(negedge clock);
         bus_a.tx_data = (k < 2) ? d[k+1] : 10'h3FF;
         if (k == 2) bus_a.start = 1'b0;
      end
      wait_drain();
   endtask

   task automatic run_reset_abort();
      exp_t e;
      int   p;
      @(negedge clock);
      bus_a.tx_data = 10'h3C3;
      bus_a.start   = 1'b1;
      p = cyc + 1;
      e.data = 10'h3C3;
      e.acc  = p;
      sb.push_back(e);
      @(negedge clock);
      bus_a.start = 1'b0;
      while (cyc < p + 39) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check_eq("abort_t", cyc - p, 40);
      check_eq("abort_ssel", bus_a.ssel, 1);
      check_eq("abort_sclk", bus_a.sclk, 0);
      check_eq("abort_busy", bus_a.busy, 0);
      check_eq("abort_rx_data", bus_a.rx_data, 0);
      check_eq("abort_done", bus_a.done, 0);
      @(negedge clock);
      reset = 1'b0;
      check_eq("abort_dropped", sb.size(), 0);
   endtask

   task automatic run_fast_dut();
      int p;
      int g = 0;
      bit seen_fall = 1'b0;
      bit seen_done = 1'b0;
      @(negedge clock);
      bus_b.tx_data = 8'hA5;
      bus_b.start   = 1'b1;
      p = cyc + 1;
      @(negedge clock);
      bus_b.start   = 1'b0;
      bus_b.tx_data = 8'h00;
      while (!seen_fall && g < 300) begin
         @(negedge clock);
         g++;
         if (bus_b.done) begin
            seen_done = 1'b1;
            check_eq("b_rx_data", bus_b.rx_data, 8'hA5);
            check_eq("b_done_t", cyc - p, B_DIV * 17);
         end
         if (!bus_b.busy) begin
            seen_fall = 1'b1;
            check_eq("b_busy_fall_t", cyc - p, B_DIV * 18);
         end
      end
      check_eq("b_done_seen", seen_done, 1);
      check_eq("b_finished", seen_fall, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bus_a.start   = 1'b0;
      bus_a.tx_data = '0;
      bus_b.start   = 1'b0;
      bus_b.tx_data = '0;
      repeat (3) @(negedge clock);
      check_eq("rst_busy", bus_a.busy, 0);
      check_eq("rst_done", bus_a.done, 0);
      check_eq("rst_rx_data", bus_a.rx_data, 0);
      check_eq("rst_sclk", bus_a.sclk, 0);
      check_eq("rst_ssel", bus_a.ssel, 1);
      check_eq("rst_mosi", bus_a.mosi, 0);
      reset = 1'b0;
      repeat (2) @(negedge clock);

      run_xfer(10'h2B5, 10'h2B5);

      mode_slave = 1'b1;
      run_xfer(10'h0F3, 10'h155);
      check_eq("slave_latched", s_latched, 10'h0F3);
      mode_slave = 1'b0;

      run_back_to_back();
      run_reset_abort();
      run_xfer(10'h1A6, 10'h1A6);

      mode_slave = 1'b1;
      glitch_en  = 1'b1;
      run_xfer(10'h2D2, 10'h155);
      check_eq("glitch_slave_latched", s_latched, 10'h2D2);
      glitch_en  = 1'b0;
      mode_slave = 1'b0;

      run_fast_dut();

      repeat (4) @(negedge clock);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire
